// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the digit width, the FSM state type and the overflow threshold helper.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam logic [3:0]  BCD_NINE    = 4'd9;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Largest value representable in the given number of decimal digits.
    function automatic int unsigned max_bcd(input int unsigned digits);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adjust (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    always_comb begin
        digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter: one bit per cycle, results
// registered on completion and held until the next conversion finishes.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [BIN_W-1:0]                bin_in,
    output logic                            busy,
    output logic                            done,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_out,
    output logic                            ovf
);

    localparam int unsigned ACC_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    state_t             state, state_next;
    logic [BIN_W-1:0]   shreg, sh_shift;
    logic [ACC_W-1:0]   acc, adj, acc_shift;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_pend;
    logic               last;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_in  (acc[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (adj[k*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Carry out of the top digit falls off the left end; only matters on overflow.
    always_comb begin
        {acc_shift, sh_shift} = {adj, shreg} << 1;
        last                  = (cnt == CNT_W'(BIN_W - 1));
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (last)  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            ovf      <= 1'b0;
            shreg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
        end else begin
            busy <= (state_next == ST_SHIFT);
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg    <= bin_in;
                        acc      <= '0;
                        cnt      <= '0;
                        // Overflow is decided from the captured value, before shifting consumes it.
                        ovf_pend <= 32'(bin_in) > max_bcd(DIGITS);
                    end
                end
                ST_SHIFT: begin
                    shreg <= sh_shift;
                    acc   <= acc_shift;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        done    <= 1'b1;
                        ovf     <= ovf_pend;
                        bcd_out <= ovf_pend ? {DIGITS{BCD_NINE}} : acc_shift;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: two converter instances (8-bit and 10-bit input, 3 digits)
// compared every cycle against a decimal-arithmetic reference, plus directed cases.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, start_a, start_b;
    logic [7:0]  bin_a;
    logic [9:0]  bin_b;
    logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
    logic [11:0] bcd_a, bcd_b;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .bin_in(bin_a),
        .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .ovf(ovf_a)
    );

    bin_to_bcd_seq #(.BIN_W(10), .DIGITS(3)) u_dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .bin_in(bin_b),
        .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .ovf(ovf_b)
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned pow10(input int unsigned d);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    // Decimal digits of v, or all nines when v does not fit in d digits.
    function automatic logic [19:0] ref_bcd(input int unsigned v, input int unsigned d);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int unsigned k = 0; k < d; k++) begin
            if (v >= pow10(d)) r[4*k +: 4] = 4'd9;
            else begin
                r[4*k +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
        return r;
    endfunction

    // Reference: a conversion accepted at an idle edge completes BIN_W edges later.
    int unsigned rem    [2];
    int unsigned pend   [2];
    logic [19:0] e_bcd  [2];
    logic        e_ovf  [2];
    logic        e_done [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            rem[i] = 0; pend[i] = 0; e_bcd[i] = '0; e_ovf[i] = 1'b0; e_done[i] = 1'b0;
        end
    end

    always begin
        logic        rs, st;
        int unsigned bv, bw;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            rs = (i == 0) ? rst_a : rst_b;
            st = (i == 0) ? start_a : start_b;
            bv = (i == 0) ? int'(bin_a) : int'(bin_b);
            bw = (i == 0) ? 8 : 10;
            e_done[i] = 1'b0;
            if (rs) begin
                rem[i] = 0; e_bcd[i] = '0; e_ovf[i] = 1'b0;
            end else if (rem[i] > 0) begin
                rem[i]--;
                if (rem[i] == 0) begin
                    e_done[i] = 1'b1;
                    e_bcd[i]  = ref_bcd(pend[i], 3);
                    e_ovf[i]  = (pend[i] > 999);
                end
            end else if (st) begin
                rem[i]  = bw;
                pend[i] = bv;
            end
        end
        #1;
        check("a_busy", busy_a, (rem[0] > 0) ? 1 : 0);
        check("a_done", done_a, e_done[0]);
        check("a_bcd",  bcd_a,  e_bcd[0][11:0]);
        check("a_ovf",  ovf_a,  e_ovf[0]);
        check("b_busy", busy_b, (rem[1] > 0) ? 1 : 0);
        check("b_done", done_b, e_done[1]);
        check("b_bcd",  bcd_b,  e_bcd[1][11:0]);
        check("b_ovf",  ovf_b,  e_ovf[1]);
    end

    task automatic drive(input int idx, input logic s, input int unsigned v);
        if (idx == 0) begin start_a = s; bin_a = 8'(v); end
        else          begin start_b = s; bin_b = 10'(v); end
    endtask

    function automatic logic get_done(input int idx);
        return (idx == 0) ? done_a : done_b;
    endfunction

    function automatic logic [11:0] get_bcd(input int idx);
        return (idx == 0) ? bcd_a : bcd_b;
    endfunction

    function automatic logic get_ovf(input int idx);
        return (idx == 0) ? ovf_a : ovf_b;
    endfunction

    // One conversion; start is re-asserted with 42 during cycles spam_lo..spam_hi.
    task automatic conv(input int idx, input int unsigned v, input int unsigned spam_lo,
                        input int unsigned spam_hi, input logic [11:0] exp_bcd, input logic exp_ovf);
        int unsigned n, extra;
        logic got;
        @(negedge clk);
        drive(idx, 1'b1, v);
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1; n++;
            if (n >= spam_lo && n <= spam_hi) drive(idx, 1'b1, 42);
            else drive(idx, 1'b0, v);
            if (get_done(idx)) got = 1'b1;
        end
        check("conv_latency", n, (idx == 0) ? 9 : 11);
        check("conv_bcd", get_bcd(idx), exp_bcd);
        check("conv_ovf", get_ovf(idx), exp_ovf);
        extra = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (get_done(idx)) extra++;
        end
        check("conv_no_extra_done", extra, 0);
        check("conv_hold_bcd", get_bcd(idx), exp_bcd);
    endtask

    initial begin
        int unsigned n, seen, dn;
        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0; bin_a = '0; bin_b = '0;

        check("pin_255",  ref_bcd(255, 3),  'h255);
        check("pin_7",    ref_bcd(7, 3),    'h007);
        check("pin_999",  ref_bcd(999, 3),  'h999);
        check("pin_1023", ref_bcd(1023, 3), 'h999);

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        check("reset_bcd",  bcd_a,  0);
        check("reset_ovf",  ovf_a,  0);
        rst_a = 1'b0; rst_b = 1'b0;

        conv(0, 0,   99, 99, 12'h000, 1'b0);
        conv(0, 255, 99, 99, 12'h255, 1'b0);
        conv(0, 99,  99, 99, 12'h099, 1'b0);
        conv(0, 7,   99, 99, 12'h007, 1'b0);
        conv(0, 128, 3,  5,  12'h128, 1'b0);

        // start held high; second value presented in the done cycle
        @(negedge clk);
        drive(0, 1'b1, 10);
        n = 0; seen = 0;
        while (seen < 2 && n < 40) begin
            @(posedge clk); #1; n++;
            if (done_a) begin
                seen++;
                if (seen == 1) begin
                    check("b2b_first_cycle", n, 9);
                    check("b2b_first_bcd", bcd_a, 12'h010);
                    drive(0, 1'b1, 11);
                end else begin
                    check("b2b_second_cycle", n, 18);
                    check("b2b_second_bcd", bcd_a, 12'h011);
                    drive(0, 1'b0, 0);
                end
            end
        end
        check("b2b_done_count", seen, 2);
        drive(0, 1'b0, 0);
        repeat (3) @(posedge clk);

        // reset during a conversion of 200
        @(negedge clk);
        drive(0, 1'b1, 200);
        for (int unsigned c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c == 1) drive(0, 1'b0, 200);
            if (c == 4) rst_a = 1'b1;
            if (c == 5) begin
                rst_a = 1'b0;
                check("abort_busy", busy_a, 0);
                check("abort_bcd",  bcd_a,  0);
                check("abort_ovf",  ovf_a,  0);
            end
        end
        dn = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done_a) dn++;
        end
        check("abort_no_done", dn, 0);
        conv(0, 200, 99, 99, 12'h200, 1'b0);

        conv(1, 1023, 99, 99, 12'h999, 1'b1);
        conv(1, 999,  99, 99, 12'h999, 1'b0);
        conv(1, 1000, 99, 99, 12'h999, 1'b1);
        conv(1, 512,  4,  7,  12'h512, 1'b0);

        // random traffic on both instances, checked by the reference every cycle
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            start_a = ($urandom_range(0, 3) == 0);
            bin_a   = 8'($urandom);
            rst_a   = ($urandom_range(0, 199) == 0);
            start_b = ($urandom_range(0, 2) == 0);
            bin_b   = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom);
            rst_b   = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
        repeat (15) @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
